ripple_carry_adder_arbiter: RTL and testbench

Round-robin arbiter that shares one `ripple_carry_adder` instance between `NUM_REQ` requesters. Each requester presents two `WIDTH`-bit operands with a valid/ready handshake. The arbiter grants one requester per cycle and drives the granted operands into the adder. It registers the `WIDTH+1`-bit sum, tagged with the requester ID, into a single-entry output stage that supports backpressure. The block sits between the adder datapath and any logic that needs occasional additions without owning an adder.

---
 rtl/ripple_carry_adder_arbiter.sv | 114 +++++++++++
 tb/tb_ripple_carry_adder_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between NUM_REQ requesters,
// with a single-entry, backpressure-aware response stage and a transfer counter.

module ripple_carry_adder #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] term1,
    input  logic [WIDTH-1:0] term2,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = term1[i] ^ term2[i] ^ carry[i];
        assign carry[i+1] = (term1[i] & term2[i]) | (carry[i] & (term1[i] ^ term2[i]));
    end

    assign sum[WIDTH] = carry[WIDTH];
endmodule

module ripple_carry_adder_arbiter #(
    parameter int WIDTH   = 2,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_term1,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_term2,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_rsp_valid,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [WIDTH:0]           o_rsp_result,
    input  logic                     i_rsp_ready,
    output logic [15:0]              o_txn_count
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [ID_W-1:0]  r_prio;
    logic [ID_W-1:0]  win_id;
    logic             found;
    logic             cap;
    logic             transfer;
    int unsigned      idx;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_sum;
    logic [ID_W-1:0]  next_prio;

    assign o_rsp_valid = (state == FULL);
    assign cap         = !o_rsp_valid || i_rsp_ready;

    // Search starts at r_prio and wraps; the first valid requester wins and
    // also selects the adder operands.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        add_a  = '0;
        add_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(r_prio) + i) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
                add_a  = i_req_term1[idx*WIDTH +: WIDTH];
                add_b  = i_req_term2[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = found && cap && !i_rst;

    always_comb begin
        o_req_ready = '0;
        if (transfer) begin
            o_req_ready[win_id] = 1'b1;
        end
    end

    assign next_prio = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .term1 (add_a),
        .term2 (add_b),
        .sum   (add_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= EMPTY;
            o_rsp_id     <= '0;
            o_rsp_result <= '0;
            r_prio       <= '0;
            o_txn_count  <= '0;
        end else begin
            if (transfer) begin
                o_rsp_id     <= win_id;
                o_rsp_result <= add_sum;
                r_prio       <= next_prio;
                o_txn_count  <= o_txn_count + 16'd1;
            end
            case (state)
                EMPTY: if (transfer) state <= FULL;
                FULL:  if (i_rsp_ready && !transfer) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder_arbiter.sv
// Self-checking bench for ripple_carry_adder_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the arbiter.

module tb_ripple_carry_adder_arbiter;
    localparam int WIDTH   = 2;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] term1;
    logic [NUM_REQ*WIDTH-1:0] term2;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH:0]           rsp_result;
    logic                     rsp_ready;
    logic [15:0]              txn_count;

    always #5 clk = ~clk;

    ripple_carry_adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_term1  (term1),
        .i_req_term2  (term2),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .i_rsp_ready  (rsp_ready),
        .o_txn_count  (txn_count)
    );

    // Reference model state
    logic        m_valid  = 1'b0;
    logic [1:0]  m_id     = '0;
    logic [2:0]  m_result = '0;
    int          m_prio   = 0;
    logic [15:0] m_count  = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (m_prio + i) % NUM_REQ;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check the grant mid-cycle, advance the model at the edge,
    // then check the registered outputs just after it.
    task automatic cycle();
        int         w;
        logic [3:0] er;
        logic [2:0] a;
        logic [2:0] b;
        @(negedge clk);
        w  = pick();
        er = '0;
        if (!rst && (!m_valid || rsp_ready) && w >= 0) er[w] = 1'b1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_id = '0; m_result = '0; m_prio = 0; m_count = '0;
        end else if (er != 4'd0) begin
            a = {1'b0, term1[w*WIDTH +: WIDTH]};
            b = {1'b0, term2[w*WIDTH +: WIDTH]};
            m_valid  = 1'b1;
            m_id     = ID_W'(w);
            m_result = a + b;
            m_prio   = (w + 1) % NUM_REQ;
            m_count  = m_count + 16'd1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("rsp_valid",  {31'd0, rsp_valid},  {31'd0, m_valid});
        chk("rsp_id",     {30'd0, rsp_id},     {30'd0, m_id});
        chk("rsp_result", {29'd0, rsp_result}, {29'd0, m_result});
        chk("txn_count",  {16'd0, txn_count},  {16'd0, m_count});
    endtask

    logic [2:0] s3_res [5];
    logic [1:0] s3_id  [5];

    initial begin
        rst = 1'b1; req_valid = '1; term1 = '0; term2 = '0; rsp_ready = 1'b1;

        // Scenario 1: reset with all requests valid
        cycle(); cycle();
        chk("s1_count", {16'd0, txn_count}, 32'd0);

        // Scenario 2: single request from requester 1
        rst = 1'b0; req_valid = 4'b0010;
        term1 = 8'b00_00_10_00; term2 = 8'b00_00_01_00;
        cycle();
        chk("s2_id",     {30'd0, rsp_id},     32'd1);
        chk("s2_result", {29'd0, rsp_result}, 32'b011);
        chk("s2_count",  {16'd0, txn_count},  32'd1);

        // Scenario 3: full contention from a fresh pointer
        rst = 1'b1; cycle();
        rst = 1'b0; req_valid = 4'b1111;
        term1 = 8'b11_01_10_00; term2 = 8'b11_11_01_01;
        s3_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        s3_res = '{3'b001, 3'b011, 3'b100, 3'b110, 3'b001};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("s3_id",     {30'd0, rsp_id},     {30'd0, s3_id[i]});
            chk("s3_result", {29'd0, rsp_result}, {29'd0, s3_res[i]});
        end

        // Scenario 4: backpressure for 3 cycles, then no-bubble resume
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s4_hold_result", {29'd0, rsp_result}, 32'b001);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("s4_resume_id", {30'd0, rsp_id}, 32'd1);
        chk("s4_resume_valid", {31'd0, rsp_valid}, 32'd1);

        // Scenario 5: pointer wrap after a grant to requester 3
        req_valid = 4'b1000; cycle();
        chk("s5_grant3", {30'd0, rsp_id}, 32'd3);
        req_valid = 4'b1001; cycle();
        chk("s5_first0", {30'd0, rsp_id}, 32'd0);
        cycle();
        chk("s5_then3", {30'd0, rsp_id}, 32'd3);

        // Scenario 6: reset while FULL with pointer at 2
        req_valid = 4'b0010; cycle();
        req_valid = 4'b1010; rst = 1'b1; cycle();
        chk("s6_rst_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0; cycle();
        chk("s6_first_id", {30'd0, rsp_id}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom);
            term1     = 8'($urandom);
            term2     = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
